// File: rtl/wave_analyzer.sv
// wave_analyzer: recovers period, peak-to-peak amplitude and band
// from a 4-bit sampled waveform using a hysteretic crossing detector.
module wave_analyzer #(
  parameter int THRESH     = 8,
  parameter int HYST       = 1,
  parameter int CNT_W      = 10,
  parameter int MAX_PERIOD = 1023,
  parameter int LOW_P      = 64,
  parameter int HIGH_P     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [3:0]       wave_in,
  output logic [CNT_W-1:0] period_out,
  output logic [3:0]       amp_out,
  output logic [1:0]       freq_label,
  output logic             meas_valid,
  output logic             no_signal
);

  localparam logic [1:0] S_SYNC   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_RUN_HI = 2'd2;
  localparam logic [1:0] S_RUN_LO = 2'd3;

  localparam logic [4:0] HI_V = 5'(THRESH + HYST);
  localparam logic [4:0] LO_V = 5'(THRESH - HYST);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(MAX_PERIOD - 1);
  localparam logic [CNT_W-1:0] LOW_V  = CNT_W'(LOW_P);
  localparam logic [CNT_W-1:0] HIGH_V = CNT_W'(HIGH_P);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       max_q, max_d;
  logic [3:0]       min_q, min_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [3:0]       amp_q, amp_d;
  logic [1:0]       label_q, label_d;
  logic             mv_q, mv_d;
  logic             ns_q, ns_d;

  logic             is_low;
  logic             is_rise;
  logic [CNT_W-1:0] p;
  logic [3:0]       hi_s;
  logic [3:0]       lo_s;

  assign is_low  = {1'b0, wave_in} <= LO_V;
  assign is_rise = {1'b0, wave_in} >= HI_V;
  assign p       = cnt_q + CNT_W'(1);
  assign hi_s    = (wave_in > max_q) ? wave_in : max_q;
  assign lo_s    = (wave_in < min_q) ? wave_in : min_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    min_d    = min_q;
    period_d = period_q;
    amp_d    = amp_q;
    label_d  = label_q;
    mv_d     = 1'b0;
    ns_d     = ns_q;
    if (sample_en) begin
      case (state_q)
        S_SYNC: begin
          if (is_low) state_d = S_ARM;
        end
        S_ARM: begin
          if (is_rise) begin
            state_d = S_RUN_HI;
            cnt_d   = '0;
            max_d   = wave_in;
            min_d   = wave_in;
          end
        end
        default: begin
          // timeout wins over an emit on the same sample
          if (cnt_q == TO_CNT) begin
            state_d  = S_SYNC;
            cnt_d    = '0;
            period_d = '0;
            amp_d    = '0;
            label_d  = 2'b11;
            ns_d     = 1'b1;
          end else if (state_q == S_RUN_LO && is_rise) begin
            period_d = p;
            amp_d    = hi_s - lo_s;
            if (p >= LOW_V)       label_d = 2'b00;
            else if (p < HIGH_V)  label_d = 2'b10;
            else                  label_d = 2'b01;
            mv_d     = 1'b1;
            ns_d     = 1'b0;
            cnt_d    = '0;
            max_d    = wave_in;
            min_d    = wave_in;
            state_d  = S_RUN_HI;
          end else begin
            cnt_d = p;
            max_d = hi_s;
            min_d = lo_s;
            if (state_q == S_RUN_HI && is_low) state_d = S_RUN_LO;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_SYNC;
      cnt_q    <= '0;
      max_q    <= '0;
      min_q    <= '0;
      period_q <= '0;
      amp_q    <= '0;
      label_q  <= 2'b11;
      mv_q     <= 1'b0;
      ns_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      min_q    <= min_d;
      period_q <= period_d;
      amp_q    <= amp_d;
      label_q  <= label_d;
      mv_q     <= mv_d;
      ns_q     <= ns_d;
    end
  end

  assign period_out = period_q;
  assign amp_out    = amp_q;
  assign freq_label = label_q;
  assign meas_valid = mv_q;
  assign no_signal  = ns_q;

endmodule

// File: tb/tb_wave_analyzer.sv
// tb_wave_analyzer: directed square-wave stimulus with a scoreboard
// queue of expected measurement/timeout events.
module tb_wave_analyzer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic [3:0] wave_in;
  logic [9:0] period_out;
  logic [3:0] amp_out;
  logic [1:0] freq_label;
  logic       meas_valid;
  logic       no_signal;

  wave_analyzer dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .wave_in    (wave_in),
    .period_out (period_out),
    .amp_out    (amp_out),
    .freq_label (freq_label),
    .meas_valid (meas_valid),
    .no_signal  (no_signal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit to;
    int cyc;
    int p;
    int a;
    int l;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mv_count = 0;
  logic ns_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops one expectation per meas_valid pulse or timeout edge
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (meas_valid || (no_signal && !ns_prev)) begin
        if (meas_valid) mv_count++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: mv=%0b ns=%0b at cycle %0d, none expected",
                   meas_valid, no_signal, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("event_kind", int'(!meas_valid), int'(e.to));
          chk("event_cycle", cyc, e.cyc);
          chk("period_out", int'(period_out), e.p);
          chk("amp_out", int'(amp_out), e.a);
          chk("freq_label", int'(freq_label), e.l);
          chk("no_signal", int'(no_signal), int'(e.to));
        end
      end
    end
    ns_prev = no_signal;
  end

  task automatic drive(input logic [3:0] v, input logic en);
    @(negedge clk);
    wave_in   = v;
    sample_en = en;
  endtask

  task automatic exp_meas(input int p, input int a, input int l);
    q.push_back('{1'b0, cyc + 1, p, a, l});
  endtask

  task automatic exp_to();
    q.push_back('{1'b1, cyc + 1, 0, 0, 3});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_period"}, int'(period_out), 0);
    chk({tag, "_amp"}, int'(amp_out), 0);
    chk({tag, "_label"}, int'(freq_label), 3);
    chk({tag, "_mv"}, int'(meas_valid), 0);
    chk({tag, "_ns"}, int'(no_signal), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    sample_en = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
  endtask

  task automatic square(input logic [3:0] lo, input logic [3:0] hi,
                        input int nlo, input int nhi, input int reps,
                        input bit first_emit, input int ep, input int ea,
                        input int el, input bit gap);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < nlo; i++) begin
        drive(lo, 1'b1);
        if (gap) drive(lo, 1'b0);
      end
      for (int i = 0; i < nhi; i++) begin
        drive(hi, 1'b1);
        if (i == 0 && (r > 0 || first_emit)) exp_meas(ep, ea, el);
        if (gap) drive(hi, 1'b0);
      end
    end
  endtask

  initial begin
    int mv0;
    reset     = 1'b1;
    sample_en = 1'b0;
    wave_in   = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("init");
    reset = 1'b0;

    // 20-cycle square wave, 2/14
    square(4'd2, 4'd14, 10, 10, 4, 1'b0, 20, 12, 1, 1'b0);

    // hysteresis band only: never locks
    do_reset();
    mv0 = mv_count;
    for (int i = 0; i < 2000; i++) drive((i % 2) ? 4'd9 : 4'd8, 1'b1);
    @(negedge clk);
    chk("hyst_mv_count", mv_count, mv0);
    chk("hyst_ns", int'(no_signal), 1);
    chk("hyst_label", int'(freq_label), 3);

    // gapped sampling, period 8
    do_reset();
    square(4'd1, 4'd15, 4, 4, 4, 1'b0, 8, 14, 2, 1'b1);

    // band boundaries
    do_reset();
    square(4'd2, 4'd14, 7, 8, 3, 1'b0, 15, 12, 2, 1'b0);
    do_reset();
    square(4'd2, 4'd14, 8, 8, 3, 1'b0, 16, 12, 1, 1'b0);
    do_reset();
    square(4'd0, 4'd15, 31, 32, 3, 1'b0, 63, 15, 1, 1'b0);
    do_reset();
    square(4'd3, 4'd12, 32, 32, 3, 1'b0, 64, 9, 0, 1'b0);

    // timeout after lock, then recovery
    do_reset();
    square(4'd2, 4'd14, 10, 10, 3, 1'b0, 20, 12, 1, 1'b0);
    for (int k = 1; k <= 1014; k++) begin
      drive(4'd14, 1'b1);
      if (k == 1014) exp_to();
    end
    for (int k = 0; k < 5; k++) drive(4'd14, 1'b1);
    @(negedge clk);
    chk("to_hold_ns", int'(no_signal), 1);
    chk("to_hold_period", int'(period_out), 0);
    square(4'd2, 4'd14, 10, 10, 3, 1'b0, 20, 12, 1, 1'b0);

    // reset mid-measurement
    do_reset();
    square(4'd2, 4'd14, 10, 10, 2, 1'b0, 20, 12, 1, 1'b0);
    drive(4'd2, 1'b1);
    @(negedge clk);
    reset     = 1'b1;
    sample_en = 1'b1;
    wave_in   = 4'd2;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset = 1'b0;
    square(4'd2, 4'd14, 10, 10, 3, 1'b0, 20, 12, 1, 1'b0);

    for (int k = 0; k < 4; k++) drive(4'd2, 1'b1);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
